// File: rtl/hedios_packet_engine_if.sv
// RX/TX packet queue signals shared by the packet engine and the host-side queues.
// The RX queue is first-word-fall-through: command/data are valid whenever rx_empty is low.
interface hedios_packet_engine_if;
  logic        rx_empty;
  logic        rx_lost_data;
  logic [7:0]  rx_command;
  logic [31:0] rx_data;
  logic        rx_pop_packet;
  logic        tx_full;
  logic [7:0]  tx_command;
  logic [31:0] tx_data;
  logic        tx_push_packet;

  modport master (
    input  rx_empty, rx_lost_data, rx_command, rx_data, tx_full,
    output rx_pop_packet, tx_command, tx_data, tx_push_packet
  );

  modport slave (
    output rx_empty, rx_lost_data, rx_command, rx_data, tx_full,
    input  rx_pop_packet, tx_command, tx_data, tx_push_packet
  );
endinterface

// File: rtl/hedios_packet_engine.sv
// Host command engine: decodes one RX packet per pass, drives slot/action/reset side effects,
// answers on TX and interleaves periodic stream samples of a read slot.
module hedios_packet_engine #(
  parameter int unsigned RD_SLOT_COUNT = 4,
  parameter int unsigned WR_SLOT_COUNT = 2,
  parameter int unsigned ACTION_COUNT  = 2,
  parameter logic [15:0] VERSION       = 16'h0002,
  parameter int unsigned RST_PULSE     = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  hedios_packet_engine_if.master      bus,
  input  logic [32*RD_SLOT_COUNT-1:0] rd_slots,
  output logic [32*WR_SLOT_COUNT-1:0] wr_slots,
  output logic [ACTION_COUNT-1:0]     action_req,
  input  logic [ACTION_COUNT-1:0]     action_ack,
  output logic [32*ACTION_COUNT-1:0]  action_param,
  output logic                        rst_device
);

  localparam int unsigned RdW  = (RD_SLOT_COUNT > 1) ? $clog2(RD_SLOT_COUNT) : 1;
  localparam int unsigned WrW  = (WR_SLOT_COUNT > 1) ? $clog2(WR_SLOT_COUNT) : 1;
  localparam int unsigned ActW = (ACTION_COUNT > 1) ? $clog2(ACTION_COUNT) : 1;
  localparam int unsigned RstW = $clog2(RST_PULSE + 1);

  localparam logic [7:0] CmdPing     = 8'h01;
  localparam logic [7:0] CmdRead     = 8'h02;
  localparam logic [7:0] CmdWrIdx    = 8'h03;
  localparam logic [7:0] CmdWrData   = 8'h04;
  localparam logic [7:0] CmdSetParam = 8'h05;
  localparam logic [7:0] CmdAction   = 8'h06;
  localparam logic [7:0] CmdStream   = 8'h07;
  localparam logic [7:0] CmdRstDev   = 8'h08;
  localparam logic [7:0] RspPing     = 8'h81;
  localparam logic [7:0] RspStream   = 8'h90;
  localparam logic [7:0] RspErr      = 8'hEE;

  typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

  state_e                  state_q, state_d;
  logic [7:0]              cmd_q, cmd_d;
  logic [31:0]             data_q, data_d;
  logic [7:0]              resp_cmd_q, resp_cmd_d;
  logic [31:0]             resp_data_q, resp_data_d;
  logic [15:0]             wr_idx_q, wr_idx_d;
  logic [31:0]             param_q, param_d;
  logic [31:0]             wr_slots_q [WR_SLOT_COUNT];
  logic [31:0]             wr_slots_d [WR_SLOT_COUNT];
  logic [ACTION_COUNT-1:0] action_req_q, action_req_d;
  logic [31:0]             action_param_q [ACTION_COUNT];
  logic [31:0]             action_param_d [ACTION_COUNT];
  logic [RdW-1:0]          stream_idx_q, stream_idx_d;
  logic [15:0]             period_q, period_d;
  logic [15:0]             period_cnt_q, period_cnt_d;
  logic                    stream_pend_q, stream_pend_d;
  logic [31:0]             stream_data_q, stream_data_d;
  logic [7:0]              drop_cnt_q, drop_cnt_d;
  logic                    lost_sticky_q, lost_sticky_d;
  logic [RstW-1:0]         rst_cnt_q, rst_cnt_d;

  logic [31:0] rd_arr [RD_SLOT_COUNT];
  logic [15:0] idx;
  logic        rd_ok, wr_ok, act_ok, wr_idx_ok;
  logic        tick, resp_push, stream_push;
  logic [31:0] err_range, err_busy, err_unknown;

  for (genvar i = 0; i < RD_SLOT_COUNT; i++) begin : g_rd
    assign rd_arr[i] = rd_slots[32*i +: 32];
  end
  for (genvar i = 0; i < WR_SLOT_COUNT; i++) begin : g_wr
    assign wr_slots[32*i +: 32] = wr_slots_q[i];
  end
  for (genvar i = 0; i < ACTION_COUNT; i++) begin : g_act
    assign action_param[32*i +: 32] = action_param_q[i];
  end

  assign idx         = data_q[15:0];
  assign rd_ok       = {16'h0, idx} < RD_SLOT_COUNT;
  assign wr_ok       = {16'h0, idx} < WR_SLOT_COUNT;
  assign act_ok      = {16'h0, idx} < ACTION_COUNT;
  assign wr_idx_ok   = {16'h0, wr_idx_q} < WR_SLOT_COUNT;
  assign err_range   = {16'h0, 8'h01, cmd_q};
  assign err_unknown = {16'h0, 8'h02, cmd_q};
  assign err_busy    = {16'h0, 8'h03, cmd_q};

  // A command response always wins the TX port; the stream sample waits for a free cycle.
  assign resp_push   = (state_q == StResp) & ~bus.tx_full;
  assign stream_push = stream_pend_q & ~bus.tx_full & ~resp_push;

  assign bus.tx_push_packet = resp_push | stream_push;
  assign bus.tx_command     = resp_push ? resp_cmd_q : (stream_push ? RspStream : 8'h00);
  assign bus.tx_data        = resp_push ? resp_data_q : (stream_push ? stream_data_q : 32'h0);
  // Gated by rst so the pop strobe stays low while reset is held even if the queue is not empty.
  assign bus.rx_pop_packet  = rst & (state_q == StIdle) & ~bus.rx_empty;
  assign action_req         = action_req_q;
  assign rst_device         = (rst_cnt_q != '0);

  always_comb begin
    state_d        = state_q;
    cmd_d          = cmd_q;
    data_d         = data_q;
    resp_cmd_d     = resp_cmd_q;
    resp_data_d    = resp_data_q;
    wr_idx_d       = wr_idx_q;
    param_d        = param_q;
    wr_slots_d     = wr_slots_q;
    action_req_d   = action_req_q & ~action_ack;
    action_param_d = action_param_q;
    stream_idx_d   = stream_idx_q;
    period_d       = period_q;
    period_cnt_d   = period_cnt_q;
    stream_pend_d  = stream_pend_q & ~stream_push;
    stream_data_d  = stream_data_q;
    drop_cnt_d     = drop_cnt_q;
    lost_sticky_d  = lost_sticky_q;
    rst_cnt_d      = (rst_cnt_q != '0) ? rst_cnt_q - RstW'(1) : rst_cnt_q;
    tick           = 1'b0;

    if (period_q != 16'h0) begin
      if (period_cnt_q == period_q - 16'h1) begin
        tick         = 1'b1;
        period_cnt_d = 16'h0;
      end else begin
        period_cnt_d = period_cnt_q + 16'h1;
      end
    end

    // Single-entry stream buffer: a tick that finds it still occupied is counted as a drop.
    if (tick) begin
      if (stream_pend_d) begin
        if (drop_cnt_q != 8'hFF) drop_cnt_d = drop_cnt_q + 8'h1;
      end else begin
        stream_pend_d = 1'b1;
        stream_data_d = rd_arr[stream_idx_q];
      end
    end

    if (resp_push && resp_cmd_q == RspPing) lost_sticky_d = 1'b0;
    if (bus.rx_lost_data) lost_sticky_d = 1'b1;

    unique case (state_q)
      StIdle: begin
        if (!bus.rx_empty) begin
          cmd_d   = bus.rx_command;
          data_d  = bus.rx_data;
          state_d = StExec;
        end
      end
      StExec: begin
        state_d     = StResp;
        resp_cmd_d  = cmd_q | 8'h80;
        resp_data_d = data_q;
        case (cmd_q)
          CmdPing: begin
            resp_data_d = {VERSION, drop_cnt_q, 7'h0, lost_sticky_q};
            drop_cnt_d  = 8'h0;
          end
          CmdRead: begin
            if (rd_ok) resp_data_d = rd_arr[idx[RdW-1:0]];
            else begin resp_cmd_d = RspErr; resp_data_d = err_range; end
          end
          CmdWrIdx: begin
            if (wr_ok) begin
              wr_idx_d    = idx;
              resp_data_d = {16'h0, idx};
            end else begin resp_cmd_d = RspErr; resp_data_d = err_range; end
          end
          CmdWrData: begin
            if (wr_idx_ok) begin
              wr_slots_d[wr_idx_q[WrW-1:0]] = data_q;
              resp_data_d = {16'h0, wr_idx_q};
            end else begin resp_cmd_d = RspErr; resp_data_d = err_range; end
          end
          CmdSetParam: param_d = data_q;
          CmdAction: begin
            if (!act_ok) begin
              resp_cmd_d  = RspErr;
              resp_data_d = err_range;
            end else if (action_req_q[idx[ActW-1:0]] && !action_ack[idx[ActW-1:0]]) begin
              resp_cmd_d  = RspErr;
              resp_data_d = err_busy;
            end else begin
              action_param_d[idx[ActW-1:0]] = param_q;
              action_req_d[idx[ActW-1:0]]   = 1'b1;
              resp_data_d = {16'h0, idx};
            end
          end
          CmdStream: begin
            if (data_q[31:16] != 16'h0 && !rd_ok) begin
              resp_cmd_d  = RspErr;
              resp_data_d = err_range;
            end else begin
              stream_idx_d = idx[RdW-1:0];
              period_d     = data_q[31:16];
              period_cnt_d = 16'h0;
            end
          end
          CmdRstDev: rst_cnt_d = RstW'(RST_PULSE);
          default: begin
            resp_cmd_d  = RspErr;
            resp_data_d = err_unknown;
          end
        endcase
      end
      StResp: begin
        if (!bus.tx_full) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= StIdle;
      cmd_q          <= '0;
      data_q         <= '0;
      resp_cmd_q     <= '0;
      resp_data_q    <= '0;
      wr_idx_q       <= '0;
      param_q        <= '0;
      wr_slots_q     <= '{default: '0};
      action_req_q   <= '0;
      action_param_q <= '{default: '0};
      stream_idx_q   <= '0;
      period_q       <= '0;
      period_cnt_q   <= '0;
      stream_pend_q  <= 1'b0;
      stream_data_q  <= '0;
      drop_cnt_q     <= '0;
      lost_sticky_q  <= 1'b0;
      rst_cnt_q      <= '0;
    end else begin
      state_q        <= state_d;
      cmd_q          <= cmd_d;
      data_q         <= data_d;
      resp_cmd_q     <= resp_cmd_d;
      resp_data_q    <= resp_data_d;
      wr_idx_q       <= wr_idx_d;
      param_q        <= param_d;
      wr_slots_q     <= wr_slots_d;
      action_req_q   <= action_req_d;
      action_param_q <= action_param_d;
      stream_idx_q   <= stream_idx_d;
      period_q       <= period_d;
      period_cnt_q   <= period_cnt_d;
      stream_pend_q  <= stream_pend_d;
      stream_data_q  <= stream_data_d;
      drop_cnt_q     <= drop_cnt_d;
      lost_sticky_q  <= lost_sticky_d;
      rst_cnt_q      <= rst_cnt_d;
    end
  end

endmodule

// File: tb/tb_hedios_packet_engine.sv
// Scoreboard bench for hedios_packet_engine: stimulus queues RX packets and expected responses,
// a negedge monitor pops and compares every TX push.
module tb_hedios_packet_engine;
  localparam int unsigned RD = 4;
  localparam int unsigned WR = 2;
  localparam int unsigned AC = 2;

  typedef struct packed {
    logic [7:0]  cmd;
    logic [31:0] data;
  } pkt_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  hedios_packet_engine_if bus_if ();
  logic [32*RD-1:0] rd_slots;
  logic [32*WR-1:0] wr_slots;
  logic [AC-1:0]    action_req;
  logic [AC-1:0]    action_ack;
  logic [32*AC-1:0] action_param;
  logic             rst_device;

  hedios_packet_engine #(
    .RD_SLOT_COUNT(RD),
    .WR_SLOT_COUNT(WR),
    .ACTION_COUNT (AC),
    .VERSION      (16'h0002),
    .RST_PULSE    (16)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus_if),
    .rd_slots    (rd_slots),
    .wr_slots    (wr_slots),
    .action_req  (action_req),
    .action_ack  (action_ack),
    .action_param(action_param),
    .rst_device  (rst_device)
  );

  pkt_t        rxq[$];
  pkt_t        expq[$];
  pkt_t        mon_e;
  int          checks = 0;
  int          errors = 0;
  int          pop_cnt = 0;
  int          push_cnt = 0;
  logic        pop_now;
  logic [31:0] stream_exp;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic send(input logic [7:0] c, input logic [31:0] d,
                      input logic [7:0] ec, input logic [31:0] ed);
    rxq.push_back('{cmd: c, data: d});
    expq.push_back('{cmd: ec, data: ed});
  endtask

  task automatic drain();
    int n = 0;
    while ((expq.size() != 0 || rxq.size() != 0) && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (n >= 500) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d pending expected 0", expq.size());
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic wait_rst_device(input string name);
    int n = 0;
    while (rst_device !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      checks++;
      errors++;
      $display("FAIL %s: got no rst_device pulse expected one", name);
    end
  endtask

  // FWFT RX queue model: pop observed mid-cycle, queue head updated just after the edge.
  initial begin
    bus_if.rx_empty   = 1'b1;
    bus_if.rx_command = '0;
    bus_if.rx_data    = '0;
    forever begin
      @(negedge clk);
      pop_now = bus_if.rx_pop_packet;
      @(posedge clk);
      #1;
      if (pop_now) begin
        pop_cnt++;
        if (rxq.size() != 0) void'(rxq.pop_front());
      end
      bus_if.rx_empty = (rxq.size() == 0);
      if (rxq.size() != 0) begin
        bus_if.rx_command = rxq[0].cmd;
        bus_if.rx_data    = rxq[0].data;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (bus_if.tx_push_packet === 1'b1) begin
        push_cnt++;
        if (bus_if.tx_command == 8'h90) begin
          check("stream_data", {32'h0, bus_if.tx_data}, {32'h0, stream_exp});
        end else if (expq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_push: got cmd %h data %h expected none",
                   bus_if.tx_command, bus_if.tx_data);
        end else begin
          mon_e = expq.pop_front();
          check("tx_packet", {24'h0, bus_if.tx_command, bus_if.tx_data}, {24'h0, mon_e});
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int   p;
    int   cnt;
    logic found;
    rst                 = 1'b0;
    bus_if.tx_full      = 1'b0;
    bus_if.rx_lost_data = 1'b0;
    action_ack          = '0;
    stream_exp          = '0;
    rd_slots = {32'h4444_4444, 32'h3333_3333, 32'h2222_2222, 32'h1111_1111};

    repeat (3) @(negedge clk);
    check("reset_rx_tx", {22'h0, bus_if.rx_pop_packet, bus_if.tx_push_packet,
                          bus_if.tx_command, bus_if.tx_data}, 64'h0);
    check("reset_wr_slots", wr_slots, 64'h0);
    check("reset_req_rstdev", {61'h0, action_req, rst_device}, 64'h0);
    check("reset_action_param", action_param, 64'h0);
    @(posedge clk); #1 rst = 1'b1;

    // Lost-data sticky reported once, then cleared by the PING push.
    @(posedge clk); #1 bus_if.rx_lost_data = 1'b1;
    @(posedge clk); #1 bus_if.rx_lost_data = 1'b0;
    p = pop_cnt;
    send(8'h01, 32'h0, 8'h81, 32'h0002_0001);
    drain();
    check("ping_single_pop", pop_cnt - p, 1);
    send(8'h01, 32'h0, 8'h81, 32'h0002_0000);

    send(8'h03, 32'h1, 8'h83, 32'h1);
    send(8'h04, 32'hDEAD_BEEF, 8'h84, 32'h1);
    send(8'h02, 32'h9, 8'hEE, 32'h0000_0102);
    send(8'h02, 32'h2, 8'h82, 32'h3333_3333);
    send(8'h03, 32'h5, 8'hEE, 32'h0000_0103);
    send(8'h42, 32'h0, 8'hEE, 32'h0000_0242);
    drain();
    check("wr_slot1", {32'h0, wr_slots[63:32]}, {32'h0, 32'hDEAD_BEEF});
    check("wr_slot0", {32'h0, wr_slots[31:0]}, 64'h0);

    send(8'h05, 32'h55, 8'h85, 32'h55);
    send(8'h06, 32'h0, 8'h86, 32'h0);
    send(8'h06, 32'h0, 8'hEE, 32'h0000_0306);
    send(8'h06, 32'h3, 8'hEE, 32'h0000_0106);
    drain();
    check("action_req_set", {62'h0, action_req}, 64'h1);
    check("action_param0", {32'h0, action_param[31:0]}, 64'h55);
    @(posedge clk); #1 action_ack = 2'b01;
    @(negedge clk);
    check("req_held_during_ack", {62'h0, action_req}, 64'h1);
    @(posedge clk); #1 action_ack = 2'b00;
    @(negedge clk);
    check("req_cleared_after_ack", {62'h0, action_req}, 64'h0);
    send(8'h05, 32'h1234, 8'h85, 32'h1234);
    send(8'h06, 32'h1, 8'h86, 32'h1);
    drain();
    check("action_param1", {32'h0, action_param[63:32]}, 64'h1234);
    check("action_param0_kept", {32'h0, action_param[31:0]}, 64'h55);
    check("action_req1", {62'h0, action_req}, 64'h2);

    // Stream slot 2 every 4 clocks; TX blocked 12 cycles right after the 0x87 push.
    stream_exp = 32'h3333_3333;
    send(8'h07, 32'h0004_0002, 8'h87, 32'h0004_0002);
    found = 1'b0;
    for (int i = 0; i < 50 && !found; i++) begin
      @(negedge clk);
      if (bus_if.tx_push_packet && bus_if.tx_command == 8'h87) found = 1'b1;
    end
    check("stream_ack_seen", {63'h0, found}, 64'h1);
    @(posedge clk); #1 bus_if.tx_full = 1'b1;
    p = push_cnt;
    repeat (12) @(posedge clk);
    #1 bus_if.tx_full = 1'b0;
    check("no_push_while_full", push_cnt - p, 0);
    @(negedge clk);
    check("stream_first_free_cycle", {55'h0, bus_if.tx_push_packet, bus_if.tx_command},
          {55'h0, 1'b1, 8'h90});
    send(8'h01, 32'h0, 8'h81, 32'h0002_0200);
    send(8'h07, 32'h0000_0002, 8'h87, 32'h0000_0002);
    send(8'h01, 32'h0, 8'h81, 32'h0002_0000);
    drain();

    send(8'h08, 32'h0, 8'h88, 32'h0);
    wait_rst_device("rst_pulse_start");
    cnt = 0;
    while (rst_device === 1'b1 && cnt < 100) begin
      cnt++;
      @(negedge clk);
    end
    check("rst_device_len", cnt, 16);
    drain();

    // Async reset in the middle of the device-reset pulse.
    send(8'h08, 32'h0, 8'h88, 32'h0);
    wait_rst_device("rst_pulse_start2");
    repeat (3) @(negedge clk);
    check("pulse_still_high", {63'h0, rst_device}, 64'h1);
    #2 rst = 1'b0;
    #1;
    check("rst_device_async_clear", {63'h0, rst_device}, 64'h0);
    check("reset_clears_wr_slots", wr_slots, 64'h0);
    check("reset_clears_action_req", {62'h0, action_req}, 64'h0);
    @(posedge clk); #1 rst = 1'b1;

    // Reset while a PING response waits on a full TX queue: the response must vanish.
    @(posedge clk); #1 bus_if.tx_full = 1'b1;
    rxq.push_back('{cmd: 8'h01, data: 32'h0});
    repeat (8) @(posedge clk);
    check("rxq_consumed", rxq.size(), 0);
    #2 rst = 1'b0;
    p = push_cnt;
    @(posedge clk); #1 bus_if.tx_full = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    repeat (10) @(posedge clk);
    check("resp_discarded_by_reset", push_cnt - p, 0);

    check("leftover_expected", expq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hedios_packet_engine.md
HEDIOS_PACKET_ENGINE -- requirements
Module: hedios_packet_engine

Interface
REQ-001 SHALL have parameter RD_SLOT_COUNT, default 4: number of 32-bit read-only slots (>=1).
REQ-002 SHALL have parameter WR_SLOT_COUNT, default 2: number of 32-bit host-writable slots (>=1).
REQ-003 SHALL have parameter ACTION_COUNT, default 2: number of parametrised actions (>=1).
REQ-004 SHALL have parameter VERSION, default 16'h0002: value returned by PING.
REQ-005 SHALL have parameter RST_PULSE, default 16: rst_device pulse length in clocks (>=1).
REQ-006 SHALL have ports: clk in 1, the single clock; rst in 1, asynchronous reset, active-low.
REQ-007 SHALL have ports: rx_empty in 1; rx_lost_data in 1; rx_command in 8; rx_data in 32; rx_pop_packet out 1. The RX queue is first-word-fall-through.
REQ-008 SHALL have ports: tx_full in 1; tx_command out 8; tx_data out 32; tx_push_packet out 1.
REQ-009 SHALL have ports: rd_slots in 32*RD_SLOT_COUNT (slot i = bits [32i+31:32i]); wr_slots out 32*WR_SLOT_COUNT, same packing.
REQ-010 SHALL have ports: action_req out ACTION_COUNT; action_ack in ACTION_COUNT; action_param out 32*ACTION_COUNT; rst_device out 1.

Function
REQ-011 Main FSM SHALL have states IDLE, EXEC, RESP, with one decoded packet per pass.
REQ-012 IDLE: when rx_empty=0, SHALL assert rx_pop_packet for exactly 1 cycle, latch command/data, go to EXEC.
REQ-013 EXEC (1 cycle): SHALL apply the side effect, form the response, go to RESP. No RX pop SHALL occur outside IDLE.
REQ-014 RESP: SHALL assert tx_push_packet for 1 cycle only when tx_full=0, then go to IDLE. Command/data SHALL be held stable while waiting.
REQ-015 Command 0x01 PING SHALL respond 0x81 with data {VERSION, drop_cnt[7:0], 7'b0, lost_sticky}.
REQ-016 Command 0x02 READ, data[15:0]=idx, SHALL respond 0x82 with rd_slots[idx], sampled in EXEC.
REQ-017 Command 0x03 WRITE_INDEX SHALL latch wr_idx=data[15:0] and respond 0x83 with data=idx.
REQ-018 Command 0x04 WRITE_DATA SHALL write wr_slots[wr_idx]=data and respond 0x84 with data=wr_idx. The new value SHALL be visible the cycle after EXEC.
REQ-019 Command 0x05 SET_PARAM SHALL latch param_reg=data and respond 0x85 with the same data.
REQ-020 Command 0x06 ACTION, idx, SHALL load action_param[idx]=param_reg, set action_req[idx]=1, and respond 0x86 with idx.
REQ-021 action_req[i] SHALL stay 1 until action_ack[i]=1 is sampled, then clear next cycle. ACTION on a pending idx SHALL instead respond error 0xEE, code 0x03.
REQ-022 Command 0x07 STREAM SHALL set stream_idx=data[15:0] and period=data[31:16], restart the period counter, and respond 0x87. Period 0 SHALL disable streaming.
REQ-023 While streaming, on every period-th clock a stream packet 0x90 with data rd_slots[stream_idx] SHALL become pending. Sampling occurs at the tick.
REQ-024 TX arbitration: a RESP-state response SHALL win. A pending stream packet SHALL push in any cycle with tx_full=0 and no response push.
REQ-025 Stream pending depth SHALL be 1. A tick while pending SHALL drop the new sample and increment drop_cnt, which saturates at 255 and clears on PING.
REQ-026 Command 0x08 RESET_DEVICE SHALL assert rst_device for RST_PULSE cycles starting the cycle after EXEC, and respond 0x88.
REQ-027 An out-of-range idx SHALL respond 0xEE with data {16'h0, code 0x01, cmd} and cause no side effect. An unknown command SHALL use code 0x02.
REQ-028 lost_sticky SHALL set when rx_lost_data=1 and clear on PING response push, with set winning if both happen in the same cycle.
REQ-029 Ack and new ACTION on the same idx in the same EXEC cycle SHALL be treated as not pending.

Reset
REQ-030 On rst=0 asynchronously, all outputs SHALL be 0, FSM=IDLE, and wr_slots, param_reg, wr_idx, stream period, drop_cnt, lost_sticky, and pending SHALL all be 0.
REQ-031 Reset mid-RESP SHALL discard the response, and mid-pulse SHALL end rst_device immediately.

Verification
REQ-032 PING with rx_lost_data pulsed earlier -> one pop, tx 0x81 data 0x0002_0001, then a second PING gives 0x0002_0000.
REQ-033 0x03 idx 1, 0x04 0xDEADBEEF -> wr_slots[63:32]=0xDEADBEEF, responses 0x83/0x84 with data 1. READ idx 9 (RD=4) -> 0xEE data 0x0000_0102.
REQ-034 SET_PARAM 0x55, ACTION 0, ACTION 0 again -> action_req[0]=1, param 0x55, second gives 0xEE code 0x03. Ack pulse -> req clears next cycle.
REQ-035 STREAM period 4 with tx_full held high 12 cycles -> exactly 1 pending, drop_cnt=2, and the 0x90 packet is pushed on the first cycle tx_full=0.
REQ-036 RESET_DEVICE with RST_PULSE=16 -> rst_device high exactly 16 cycles and 0x88 pushed. rst asserted mid-pulse -> immediate low.
